// File: rtl/lcd_src_sched_if.sv
// Bundle of the scheduler's pixel/handshake signals.
// slave: scheduler side. master: the side that drives the sources, sink ready and select.
interface lcd_src_sched_if;
  logic        i_sel;
  logic        i_sink_ready;
  logic [23:0] o_rgb;
  logic        o_data_vld;
  logic [23:0] i_s0_rgb;
  logic        i_s0_vld;
  logic        i_s0_sof;
  logic        o_s0_ready;
  logic [23:0] i_s1_rgb;
  logic        i_s1_vld;
  logic        i_s1_sof;
  logic        o_s1_ready;
  logic        o_cur_sel;
  logic [15:0] o_underrun_cnt;
  logic [15:0] o_frame_cnt;

  modport slave (
    input  i_sel, i_sink_ready,
    input  i_s0_rgb, i_s0_vld, i_s0_sof,
    input  i_s1_rgb, i_s1_vld, i_s1_sof,
    output o_rgb, o_data_vld, o_s0_ready, o_s1_ready, o_cur_sel,
    output o_underrun_cnt, o_frame_cnt
  );

  modport master (
    output i_sel, i_sink_ready,
    output i_s0_rgb, i_s0_vld, i_s0_sof,
    output i_s1_rgb, i_s1_vld, i_s1_sof,
    input  o_rgb, o_data_vld, o_s0_ready, o_s1_ready, o_cur_sel,
    input  o_underrun_cnt, o_frame_cnt
  );
endinterface

// File: rtl/lcd_src_sched.sv
// Frame-aligned two-source pixel scheduler in front of the LCD sync generator.
// Tracks the panel raster by counting sink-ready cycles, locks the selected source
// to the raster through its SOF marker, and substitutes FILL_RGB on underrun.
// Optional build macro: LCD_SCHED_STATS_EN adds the underrun and frame counters;
// without it both counter outputs read 16'd0.
module lcd_src_sched #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter logic [23:0] FILL_RGB = 24'h000000
) (
  input  logic           clk,
  input  logic           i_rst,
  lcd_src_sched_if.slave bus
);

  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {StIdle, StSync, StStream, StRecover} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic            cur_sel_q;
  logic [23:0]     rgb_q, rgb_d;
  logic            data_vld_q;

  logic            at_origin;
  logic            at_eof;
  logic            src_vld;
  logic            src_sof;
  logic [23:0]     src_rgb;
  logic            src_ready;
  logic            underrun;

  assign at_origin = (x_q == '0) && (y_q == '0);
  assign at_eof    = bus.i_sink_ready && (x_q == X_LAST) && (y_q == Y_LAST);

  // Only the locked source is ever looked at; the other one simply waits.
  assign src_vld = cur_sel_q ? bus.i_s1_vld : bus.i_s0_vld;
  assign src_sof = cur_sel_q ? bus.i_s1_sof : bus.i_s0_sof;
  assign src_rgb = cur_sel_q ? bus.i_s1_rgb : bus.i_s0_rgb;

  assign bus.o_s0_ready = src_ready && !cur_sel_q;
  assign bus.o_s1_ready = src_ready && cur_sel_q;
  assign bus.o_rgb      = rgb_q;
  assign bus.o_data_vld = data_vld_q;
  assign bus.o_cur_sel  = cur_sel_q;

  // Raster position: advances once per pixel requested by the sync generator.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (bus.i_sink_ready) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  // Source selection is only allowed to change at frame boundaries.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      cur_sel_q <= bus.i_sel;
    end else if (at_eof) begin
      cur_sel_q <= bus.i_sel;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, source ready and the pixel to emit on this sink-ready cycle.
  always_comb begin
    state_d   = state_q;
    src_ready = 1'b0;
    rgb_d     = FILL_RGB;
    underrun  = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = StSync;
      end
      StSync: begin
        // Drain stale pixels; hold a SOF pixel until the raster reaches the origin.
        src_ready = src_vld && (!src_sof || (at_origin && bus.i_sink_ready));
        if (src_vld && src_sof && at_origin && bus.i_sink_ready) begin
          rgb_d   = src_rgb;
          state_d = StStream;
        end
      end
      StStream: begin
        src_ready = bus.i_sink_ready;
        if (bus.i_sink_ready) begin
          // Missing pixel, SOF off the origin, or no SOF at the origin all mean
          // the source has lost raster alignment.
          if (!src_vld || (src_sof != at_origin)) begin
            underrun = 1'b1;
            state_d  = at_eof ? StSync : StRecover;
          end else begin
            rgb_d = src_rgb;
            if (at_eof && (bus.i_sel != cur_sel_q)) begin
              state_d = StSync;
            end
          end
        end
      end
      StRecover: begin
        if (at_eof) begin
          state_d = StSync;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered pixel output; rgb holds its last value while no pixel is requested.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      rgb_q      <= '0;
      data_vld_q <= 1'b0;
    end else begin
      data_vld_q <= bus.i_sink_ready;
      if (bus.i_sink_ready) begin
        rgb_q <= rgb_d;
      end
    end
  end

`ifdef LCD_SCHED_STATS_EN
  logic [15:0] underrun_cnt_q;
  logic [15:0] frame_cnt_q;

  // Free-running wrap-around statistics.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      underrun_cnt_q <= '0;
      frame_cnt_q    <= '0;
    end else begin
      if (underrun) begin
        underrun_cnt_q <= underrun_cnt_q + 16'd1;
      end
      if (at_eof) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign bus.o_underrun_cnt = underrun_cnt_q;
  assign bus.o_frame_cnt    = frame_cnt_q;
`else
  logic unused_underrun;
  assign unused_underrun    = underrun;
  assign bus.o_underrun_cnt = 16'd0;
  assign bus.o_frame_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_lcd_src_sched.sv
// Directed bench for lcd_src_sched on a small 8x4 raster.
// Source N presents pixel index p with rgb = base_N + p and SOF on p == 0.
module tb_lcd_src_sched;

  localparam int unsigned H    = 8;
  localparam int unsigned V    = 4;
  localparam int          NPIX = H * V;
  localparam logic [23:0] FILL = 24'hABCDEF;
`ifdef LCD_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst;
  lcd_src_sched_if bus ();

  lcd_src_sched #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .FILL_RGB (FILL)
  ) dut (
    .clk   (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk  = 0;
  int nfail = 0;
  int p0    = 0;
  int p1    = 5;  // source 1 holds a stale partial frame
  int rc    = 0;  // raster index of the next pixel to be requested
  int vis   = -1; // raster index of the pixel now on o_rgb, -1 if none
  bit drop0;
  bit sofinj0;

  function automatic logic [23:0] ramp(input int src, input int pos);
    ramp = ((src == 0) ? 24'h100000 : 24'h200000) + 24'(pos);
  endfunction

  task automatic drive_src();
    bus.i_s0_rgb = ramp(0, p0);
    bus.i_s0_vld = !drop0;
    bus.i_s0_sof = (p0 == 0) || sofinj0;
    bus.i_s1_rgb = ramp(1, p1);
    bus.i_s1_vld = 1'b1;
    bus.i_s1_sof = (p1 == 0);
  endtask

  // One clock: sample handshakes mid-cycle, then update the source model after the edge.
  task automatic step();
    bit a0, a1, sr, rs;
    @(negedge clk);
    a0 = bus.i_s0_vld && bus.o_s0_ready;
    a1 = bus.i_s1_vld && bus.o_s1_ready;
    sr = bus.i_sink_ready;
    rs = rst;
    @(posedge clk);
    #1;
    if (a0) p0 = (p0 + 1) % NPIX;
    if (a1) p1 = (p1 + 1) % NPIX;
    if (rs) begin
      rc  = 0;
      vis = -1;
    end else if (sr) begin
      vis = rc;
      rc  = (rc + 1) % NPIX;
    end else begin
      vis = -1;
    end
    drop0   = 1'b0;
    sofinj0 = 1'b0;
    drive_src();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_sel = 1'b1;
    bus.i_sink_ready = 1'b1;
    drive_src();
    step();
    nchk++;
    if (bus.o_cur_sel !== 1'b1) begin
      nfail++; $display("FAIL reset_cur_sel1: got %b want 1", bus.o_cur_sel);
    end
    bus.i_sel = 1'b0;
    step();
    nchk++;
    if (bus.o_cur_sel !== 1'b0) begin
      nfail++; $display("FAIL reset_cur_sel0: got %b want 0", bus.o_cur_sel);
    end
    nchk++;
    if (bus.o_rgb !== 24'h0 || bus.o_data_vld !== 1'b0) begin
      nfail++; $display("FAIL reset_out: got rgb=%h vld=%b want 000000/0", bus.o_rgb,
                        bus.o_data_vld);
    end
    nchk++;
    if (bus.o_s0_ready !== 1'b0 || bus.o_s1_ready !== 1'b0) begin
      nfail++; $display("FAIL reset_ready: got %b%b want 00", bus.o_s0_ready, bus.o_s1_ready);
    end
    nchk++;
    if (bus.o_underrun_cnt !== 16'd0 || bus.o_frame_cnt !== 16'd0) begin
      nfail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.o_underrun_cnt,
                        bus.o_frame_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [23:0] want;
    // First raster frame: SYNC waits for the origin, all FILL.
    for (int i = 0; i < NPIX; i++) begin
      step();
      nchk++;
      if (bus.o_rgb !== FILL || bus.o_data_vld !== 1'b1) begin
        nfail++; $display("FAIL stream_sync pos %0d: got %h/%b want %h/1", vis, bus.o_rgb,
                          bus.o_data_vld, FILL);
      end
      if (i == 10) begin
        nchk++;
        if (bus.o_s0_ready !== 1'b0) begin
          nfail++; $display("FAIL stream_hold_sof: got %b want 0", bus.o_s0_ready);
        end
      end
    end
    // Two locked frames.
    for (int i = 0; i < 2 * NPIX; i++) begin
      step();
      want = ramp(0, vis);
      nchk++;
      if (bus.o_rgb !== want || bus.o_data_vld !== 1'b1) begin
        nfail++; $display("FAIL stream_pix pos %0d: got %h/%b want %h/1", vis, bus.o_rgb,
                          bus.o_data_vld, want);
      end
      if (i == 7) begin
        nchk++;
        if (bus.o_s0_ready !== 1'b1 || bus.o_s1_ready !== 1'b0) begin
          nfail++; $display("FAIL stream_ready: got %b%b want 10", bus.o_s0_ready,
                            bus.o_s1_ready);
        end
      end
    end
    nchk++;
    if (bus.o_frame_cnt !== (STATS ? 16'd3 : 16'd0)) begin
      nfail++; $display("FAIL stream_frame_cnt: got %0d want %0d", bus.o_frame_cnt,
                        STATS ? 3 : 0);
    end
  endtask

  task automatic test_sink_stall();
    logic [23:0] want;
    for (int i = 0; i < NPIX; i++) begin
      if (i == 10) begin
        bus.i_sink_ready = 1'b0;
        #1;
        nchk++;
        if (bus.o_s0_ready !== 1'b0) begin
          nfail++; $display("FAIL stall_ready: got %b want 0", bus.o_s0_ready);
        end
        step();
        step();
        nchk++;
        if (bus.o_data_vld !== 1'b0) begin
          nfail++; $display("FAIL stall_vld: got %b want 0", bus.o_data_vld);
        end
        bus.i_sink_ready = 1'b1;
      end
      step();
      want = ramp(0, vis);
      nchk++;
      if (bus.o_rgb !== want || bus.o_data_vld !== 1'b1) begin
        nfail++; $display("FAIL stall_pix pos %0d: got %h/%b want %h/1", vis, bus.o_rgb,
                          bus.o_data_vld, want);
      end
    end
  endtask

  // Shared shape of the underrun and misalignment scenarios:
  // frame A breaks at position brk, frame B is FILL while resyncing, frame C is clean.
  task automatic test_underrun();
    logic [23:0] want;
    for (int i = 0; i < 3 * NPIX; i++) begin
      if (i == 21) begin
        drop0 = 1'b1;
        drive_src();
      end
      step();
      if (i < NPIX) want = (vis < 21) ? ramp(0, vis) : FILL;
      else if (i < 2 * NPIX) want = FILL;
      else want = ramp(0, vis);
      nchk++;
      if (bus.o_rgb !== want) begin
        nfail++; $display("FAIL underrun_pix %0d: got %h want %h", i, bus.o_rgb, want);
      end
      if (i == 25) begin
        nchk++;
        if (bus.o_s0_ready !== 1'b0) begin
          nfail++; $display("FAIL underrun_recover_ready: got %b want 0", bus.o_s0_ready);
        end
      end
    end
    nchk++;
    if (bus.o_underrun_cnt !== (STATS ? 16'd1 : 16'd0)) begin
      nfail++; $display("FAIL underrun_cnt: got %0d want %0d", bus.o_underrun_cnt,
                        STATS ? 1 : 0);
    end
  endtask

  task automatic test_misalign();
    logic [23:0] want;
    for (int i = 0; i < 3 * NPIX; i++) begin
      if (i == 3) begin
        sofinj0 = 1'b1;
        drive_src();
      end
      step();
      if (i < NPIX) want = (vis < 3) ? ramp(0, vis) : FILL;
      else if (i < 2 * NPIX) want = FILL;
      else want = ramp(0, vis);
      nchk++;
      if (bus.o_rgb !== want) begin
        nfail++; $display("FAIL misalign_pix %0d: got %h want %h", i, bus.o_rgb, want);
      end
    end
    nchk++;
    if (bus.o_underrun_cnt !== (STATS ? 16'd2 : 16'd0)) begin
      nfail++; $display("FAIL misalign_cnt: got %0d want %0d", bus.o_underrun_cnt,
                        STATS ? 2 : 0);
    end
  endtask

  task automatic test_switch();
    logic [23:0] want;
    for (int i = 0; i < 3 * NPIX; i++) begin
      if (i == 19) bus.i_sel = 1'b1;
      step();
      if (i < NPIX) want = ramp(0, vis);
      else if (i < 2 * NPIX) want = FILL;
      else want = ramp(1, vis);
      nchk++;
      if (bus.o_rgb !== want) begin
        nfail++; $display("FAIL switch_pix %0d: got %h want %h", i, bus.o_rgb, want);
      end
      if (i == 25) begin
        nchk++;
        if (bus.o_cur_sel !== 1'b0) begin
          nfail++; $display("FAIL switch_midframe_sel: got %b want 0", bus.o_cur_sel);
        end
      end
      if (i >= NPIX) begin
        nchk++;
        if (bus.o_s0_ready !== 1'b0) begin
          nfail++; $display("FAIL switch_s0_ready %0d: got %b want 0", i, bus.o_s0_ready);
        end
      end
    end
    nchk++;
    if (bus.o_cur_sel !== 1'b1) begin
      nfail++; $display("FAIL switch_cur_sel: got %b want 1", bus.o_cur_sel);
    end
  endtask

  task automatic test_midframe_reset();
    logic [23:0] want;
    for (int i = 0; i < 20; i++) begin
      step();
      want = ramp(1, vis);
      nchk++;
      if (bus.o_rgb !== want) begin
        nfail++; $display("FAIL mrst_pre %0d: got %h want %h", i, bus.o_rgb, want);
      end
    end
    rst = 1'b1;
    bus.i_sel = 1'b0;
    step();
    rst = 1'b0;
    nchk++;
    if (bus.o_rgb !== 24'h0 || bus.o_data_vld !== 1'b0 || bus.o_s0_ready !== 1'b0 ||
        bus.o_s1_ready !== 1'b0 || bus.o_cur_sel !== 1'b0) begin
      nfail++; $display("FAIL mrst_out: got rgb=%h vld=%b rdy=%b%b sel=%b want 000000 0 00 0",
                        bus.o_rgb, bus.o_data_vld, bus.o_s0_ready, bus.o_s1_ready,
                        bus.o_cur_sel);
    end
    nchk++;
    if (bus.o_underrun_cnt !== 16'd0 || bus.o_frame_cnt !== 16'd0) begin
      nfail++; $display("FAIL mrst_cnt: got %0d/%0d want 0/0", bus.o_underrun_cnt,
                        bus.o_frame_cnt);
    end
    for (int i = 0; i < 2 * NPIX; i++) begin
      step();
      want = (i < NPIX) ? FILL : ramp(0, vis);
      nchk++;
      if (bus.o_rgb !== want || bus.o_data_vld !== 1'b1) begin
        nfail++; $display("FAIL mrst_reacq %0d: got %h/%b want %h/1", i, bus.o_rgb,
                          bus.o_data_vld, want);
      end
    end
    nchk++;
    if (bus.o_frame_cnt !== (STATS ? 16'd2 : 16'd0)) begin
      nfail++; $display("FAIL mrst_frame_cnt: got %0d want %0d", bus.o_frame_cnt,
                        STATS ? 2 : 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    drop0 = 1'b0;
    sofinj0 = 1'b0;
    bus.i_sel = 1'b0;
    bus.i_sink_ready = 1'b0;
    drive_src();
    test_reset();
    test_stream();
    test_sink_stall();
    test_underrun();
    test_misalign();
    test_switch();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_src_sched.md
# lcd_src_sched

Frame-aligned pixel-source scheduler in front of the LCD sync generator. It shares the single LCD pixel path between two streaming sources, source 0 (camera) and source 1 (CNN result/overlay). Switching happens only at frame boundaries. Source underruns are absorbed by substituting a fill colour, so the panel never loses pixel alignment. It tracks the panel raster by counting sink-ready cycles and locks each source to the raster through its start-of-frame marker.

## Interface

Parameters:

- H_ACTIVE, 800: active pixels per line
- V_ACTIVE, 480: active lines per frame
- FILL_RGB, 24'h000000: pixel emitted when no valid source pixel is available

Ports:

- clk  in  1  pixel clock (LCD divided clock domain)
- i_rst  in  1  synchronous, active-high reset
- i_sel  in  1  requested source (0 = camera, 1 = CNN); sampled only at frame boundaries
- i_sink_ready  in  1  sync generator requests one pixel this cycle (its data-enable)
- o_rgb  out  24  pixel to sync generator, {b,g,r}
- o_data_vld  out  1  o_rgb holds a pixel consumed by the previous i_sink_ready
- i_s0_rgb / i_s1_rgb  in  24  source pixel
- i_s0_vld / i_s1_vld  in  1  source pixel valid
- i_s0_sof / i_s1_sof  in  1  qualifies the current pixel as first pixel of a frame
- o_s0_ready / o_s1_ready  out  1  source pixel accepted when vld && ready
- o_cur_sel  out  1  source currently locked
- o_underrun_cnt  out  16  underrun events (stats build only)
- o_frame_cnt  out  16  completed raster frames (stats build only)

## Operation

- Raster counters: x in 0..H_ACTIVE-1 and y in 0..V_ACTIVE-1.
  - Both advance on every cycle with i_sink_ready=1, in every state, once out of reset.
  - x wraps to 0 and increments y. y wraps to 0 at end of frame (EOF: x=H_ACTIVE-1, y=V_ACTIVE-1, i_sink_ready=1).
- At reset, cur_sel is loaded from i_sel. At each EOF, cur_sel is reloaded from i_sel.
- State IDLE (reset state):
  - One cycle only; then go to SYNC.
- State SYNC:
  - o_sN_ready for the selected source is 1 while its pixel is valid and not SOF. This drains stale data.
  - The other source's ready is 0.
  - Every sink-ready cycle emits FILL_RGB.
  - Go to STREAM when all of these hold: i_sN_vld && i_sN_sof, x=0, y=0, and i_sink_ready=1. That pixel is consumed in the same cycle as the first pixel of the frame.
- State STREAM:
  - o_sN_ready for the selected source equals i_sink_ready. The other source's ready is 0.
  - On a sink-ready cycle with i_sN_vld=1, the source pixel is passed through.
  - On a sink-ready cycle with i_sN_vld=0, this is an underrun:
    - emit FILL_RGB;
    - increment the underrun counter;
    - go to RECOVER.
  - SOF seen on a consumed pixel with (x,y)≠(0,0): treat as an underrun (misalignment). The pixel is still consumed but FILL_RGB is emitted, and the state goes to RECOVER.
  - At EOF: if the newly sampled i_sel differs from cur_sel, go to SYNC. Otherwise stay in STREAM; the next consumed pixel must carry SOF.
- State RECOVER:
  - Both source readies are 0. Emit FILL_RGB for the rest of the frame.
  - At EOF go to SYNC.
- Source ready is never asserted without i_sink_ready in STREAM, so no pixel is lost.
- Reset mid-frame: counters, state, and outputs clear on the next edge. Partially consumed source frames are drained in SYNC.

## Timing

- Pixel consumption and the raster advance happen at the edge where i_sink_ready=1. o_rgb and o_data_vld are registered: they are valid in the cycle after that edge.
- Latency from source acceptance to o_rgb is 1 cycle. There is no buffering beyond the one output register.
- o_sN_ready is combinational from state, cur_sel, i_sink_ready and i_sN_vld/sof. There is no path from o_sN_ready to i_sink_ready.
- Reset values:
  - o_rgb=0, o_data_vld=0
  - o_s0_ready=o_s1_ready=0
  - o_cur_sel=i_sel at reset
  - counters=0, x=y=0, state=IDLE
- The 16-bit counters wrap to 0 on overflow.
- If i_sel changes mid-frame, the change has no effect until EOF.

## Configuration

- LCD_SCHED_STATS_EN defined: o_underrun_cnt and o_frame_cnt are implemented. o_frame_cnt increments at every EOF.
- LCD_SCHED_STATS_EN undefined: both outputs are tied to 16'd0 and no counter registers exist. Scheduling behaviour is identical.

## Test plan

- Reset then continuous sink ready, i_sel=0, source 0 streaming an SOF-marked 800×480 ramp. Required response:
  - the first frame is FILL_RGB while SYNC waits;
  - from the next raster frame, o_rgb equals the ramp pixel-for-pixel, 1 cycle after each ready.
- Toggle i_sel to 1 at pixel (100,200). Required response:
  - the remainder of the frame still comes from source 0;
  - the next frame is FILL during SYNC, then source 1 frames;
  - o_s0_ready stays 0 after the switch.
- Drop i_s0_vld for 1 cycle at (5,10). Required response:
  - FILL at that pixel and for the rest of the frame;
  - o_underrun_cnt=1;
  - SYNC, then normal data from the following SOF frame.
- Source 0 sends SOF on a pixel at (3,0). Required response: treated as misalignment, so RECOVER, then resync, with o_underrun_cnt incremented.
- Assert i_rst at mid-frame (400,240) for 1 cycle. Required response:
  - all outputs at reset values the next cycle;
  - raster restarts at (0,0);
  - stream reacquired on the next SOF.
- Build without LCD_SCHED_STATS_EN and rerun the underrun scenario. Required response: identical o_rgb trace, with counters constant 0.
